// File: rtl/wingbutled_ctrl.sv
// Button/LED wing consumer stage.
// Synchronises and debounces four raw wing buttons, classifies presses as
// short or long, and drives the four wing LEDs from a per-channel
// OFF/ON/BLINK mode machine.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   buttons[3:0] raw wing button lines (polarity set by BTN_ACTIVE_LOW)
//   clear        synchronous, forces every channel to OFF
//   leds[3:0]    LED drive, 1 = lit
//   btn_state    debounced pressed level, 1 = pressed
//   btn_press    1-cycle pulse on debounced press
//   btn_release  1-cycle pulse on debounced release
//   btn_long     1-cycle pulse when a press has been held LONG_PRESS_CYCLES
module wingbutled_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 32000,
    parameter int unsigned LONG_PRESS_CYCLES = 32000000,
    parameter int unsigned BLINK_HALF_PERIOD = 8000000,
    parameter bit          BTN_ACTIVE_LOW    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] buttons,
    input  logic       clear,
    output logic [3:0] leds,
    output logic [3:0] btn_state,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release,
    output logic [3:0] btn_long
);

    localparam int unsigned NCH = 4;
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HLW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int unsigned BKW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;

    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HLW-1:0] HOLD_MAX   = HLW'(LONG_PRESS_CYCLES);
    localparam logic [HLW-1:0] HOLD_LAST  = HLW'(LONG_PRESS_CYCLES - 1);
    localparam logic [BKW-1:0] BLINK_LAST = BKW'(BLINK_HALF_PERIOD - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2
    } mode_t;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] stable;
    logic [DBW-1:0] db_cnt [NCH];
    logic [HLW-1:0] hold_cnt [NCH];
    logic [NCH-1:0] long_flag;
    logic [BKW-1:0] blink_cnt;
    logic           phase;
    mode_t          mode_q [NCH];
    mode_t          mode_d [NCH];

    // Internal logic is active-high pressed regardless of wing polarity.
    assign raw       = buttons ^ {NCH{BTN_ACTIVE_LOW}};
    assign btn_state = stable;

    // Two-flop synchroniser, debounce counters and press/release events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            stable      <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NCH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NCH; i++) begin
                btn_press[i]   <= 1'b0;
                btn_release[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    // Mismatch held long enough: accept the new level.
                    stable[i]      <= sync2[i];
                    db_cnt[i]      <= '0;
                    btn_press[i]   <= sync2[i];
                    btn_release[i] <= ~sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // Hold counters; saturation guarantees one long pulse per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_long  <= '0;
            long_flag <= '0;
            for (int i = 0; i < NCH; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!stable[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] != HOLD_MAX) begin
                    hold_cnt[i] <= hold_cnt[i] + HLW'(1);
                end
                btn_long[i] <= stable[i] && (hold_cnt[i] == HOLD_LAST);
                // Flag marks the current press as long until its release is consumed.
                if (stable[i] && (hold_cnt[i] == HOLD_LAST)) begin
                    long_flag[i] <= 1'b1;
                end else if (btn_release[i]) begin
                    long_flag[i] <= 1'b0;
                end
            end
        end
    end

    // Shared blink phase, free-running so all BLINK channels stay in step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BKW'(1);
        end
    end

    // Mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                mode_q[i] <= MODE_OFF;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                mode_q[i] <= mode_d[i];
            end
        end
    end

    // Mode next-state: clear wins, then long press, then short-press release.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            mode_d[i] = mode_q[i];
            if (clear) begin
                mode_d[i] = MODE_OFF;
            end else if (btn_long[i]) begin
                mode_d[i] = MODE_BLINK;
            end else if (btn_release[i] && !long_flag[i]) begin
                case (mode_q[i])
                    MODE_OFF: mode_d[i] = MODE_ON;
                    MODE_ON:  mode_d[i] = MODE_OFF;
                    default:  mode_d[i] = MODE_OFF;
                endcase
            end
        end
    end

    // LED drive registered from the current mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                case (mode_q[i])
                    MODE_ON:    leds[i] <= 1'b1;
                    MODE_BLINK: leds[i] <= phase;
                    default:    leds[i] <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wingbutled_ctrl.sv
// Self-checking bench for wingbutled_ctrl with a time-based reference model.
module tb_wingbutled_ctrl;

    localparam int D = 4;
    localparam int L = 20;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] buttons;
    logic       clear;
    logic [3:0] leds;
    logic [3:0] btn_state;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_long;

    wingbutled_ctrl #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .BLINK_HALF_PERIOD(H),
        .BTN_ACTIVE_LOW   (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buttons    (buttons),
        .clear      (clear),
        .leds       (leds),
        .btn_state  (btn_state),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: e counts clock edges since reset release; raw_hist[k]
    // is the raw level sampled at edge k+1.
    int         e;
    logic [3:0] raw_hist[$];
    logic [3:0] m_state, m_press, m_rel, m_long, m_leds, m_flag;
    int         m_mode[4];   // 0 off, 1 on, 2 blink
    int         press_e[4];

    // Level the debouncer sees at edge m: raw two edges earlier.
    function automatic logic [3:0] synced_at(int m);
        if (m < 3) return 4'h0;
        return raw_hist[m-3];
    endfunction

    task automatic model_reset();
        e = 0;
        raw_hist.delete();
        m_state = '0; m_press = '0; m_rel = '0; m_long = '0; m_leds = '0; m_flag = '0;
        for (int c = 0; c < 4; c++) begin
            m_mode[c]  = 0;
            press_e[c] = 0;
        end
    endtask

    task automatic model_edge();
        logic [3:0] ns, np, nr, nl, nled, nf, smp;
        int         nm[4];
        logic       ph, flip;
        e++;
        raw_hist.push_back(buttons);
        ph = 1'(((e - 1) / H) % 2);
        for (int c = 0; c < 4; c++) begin
            flip = 1'b0;
            if (e >= D) begin
                flip = 1'b1;
                for (int i = 0; i < D; i++) begin
                    smp = synced_at(e - i);
                    if (smp[c] == m_state[c]) flip = 1'b0;
                end
            end
            nled[c] = (m_mode[c] == 1) ? 1'b1 : (m_mode[c] == 2) ? ph : 1'b0;
            nm[c] = m_mode[c];
            if (clear)                      nm[c] = 0;
            else if (m_long[c])             nm[c] = 2;
            else if (m_rel[c] && !m_flag[c]) nm[c] = (m_mode[c] == 0) ? 1 : 0;
            nl[c] = m_state[c] && ((e - press_e[c]) == L);
            nf[c] = m_flag[c];
            if (m_rel[c]) nf[c] = 1'b0;
            if (nl[c])    nf[c] = 1'b1;
            ns[c] = flip ? ~m_state[c] : m_state[c];
            np[c] = flip && !m_state[c];
            nr[c] = flip && m_state[c];
            if (np[c]) press_e[c] = e;
        end
        m_state = ns; m_press = np; m_rel = nr; m_long = nl; m_leds = nled; m_flag = nf;
        for (int c = 0; c < 4; c++) m_mode[c] = nm[c];
    endtask

    task automatic compare_all();
        check_eq("btn_state",   btn_state,   m_state);
        check_eq("btn_press",   btn_press,   m_press);
        check_eq("btn_release", btn_release, m_rel);
        check_eq("btn_long",    btn_long,    m_long);
        check_eq("leds",        leds,        m_leds);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input logic [3:0] b, input int n);
        buttons = b;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int waited;
        rst_n   = 1'b0;
        buttons = 4'hF;
        clear   = 1'b0;
        model_reset();

        // Reset held with all buttons pressed.
        #23;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 5) check_eq("t1_state_before", btn_state, 4'h0);
        end
        check_eq("t1_press_at_6", btn_press, 4'hF);
        check_eq("t1_state_at_6", btn_state, 4'hF);
        run(4'h0, 10);
        buttons = 4'h0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        run(4'h0, 3);
        check_eq("t1_cleared", leds, 4'h0);

        // Glitch rejection.
        run(4'h1, 3);
        run(4'h0, 10);
        check_eq("t2_glitch_state", btn_state, 4'h0);
        check_eq("t2_glitch_leds",  leds,      4'h0);

        // Short press toggles ON then OFF.
        run(4'h2, 10);
        run(4'h0, 12);
        check_eq("t3_led_on", leds, 4'h2);
        run(4'h2, 10);
        run(4'h0, 12);
        check_eq("t3_led_off", leds, 4'h0);

        // Long press to BLINK, release keeps blinking, short press turns off.
        run(4'h4, 30);
        run(4'h0, 12);
        run(4'h4, 10);
        run(4'h0, 12);
        check_eq("t4_led_off", leds, 4'h0);

        // Simultaneous presses, then clear colliding with a release update.
        run(4'h9, 10);
        run(4'h0, 10);
        check_eq("t5_both_on", leds, 4'h9);
        run(4'h8, 10);
        buttons = 4'h0;
        waited = 0;
        while (btn_release[3] !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        check_eq("t5_release_seen", btn_release & 4'h8, 4'h8);
        clear = 1'b1;
        step();
        clear = 1'b0;
        run(4'h0, 3);
        check_eq("t5_clear_wins", leds, 4'h0);

        // Async reset pulse in the middle of a cycle while channel 2 blinks.
        run(4'h4, 30);
        run(4'h0, 8);
        rst_n = 1'b0;
        #1;
        check_eq("t6_leds_async", leds, 4'h0);
        check_eq("t6_state_async", btn_state, 4'h0);
        model_reset();
        #2;
        rst_n = 1'b1;
        run(4'h0, 8);
        check_eq("t6_mode_off", leds, 4'h0);
        run(4'h4, 30);
        run(4'h0, 10);

        // Randomised traffic.
        for (int s = 0; s < 80; s++) begin
            int dur;
            buttons = 4'($urandom_range(0, 15));
            dur = $urandom_range(1, 32);
            for (int i = 0; i < dur; i++) begin
                clear = ($urandom_range(0, 24) == 0);
                step();
            end
            clear = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
